// File: rtl/address_unit.sv
// rtl/address_unit.sv - program counter, operand address registers and address bus mux with reset-vector fetch
module address_unit #(
  parameter logic [15:0] VEC_ADDR = 16'hFFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        increment_pc,
  input  logic        pc_load,
  input  logic        indirl_load,
  input  logic        indirh_load,
  input  logic        dirl_load,
  input  logic        dirh_load,
  input  logic [2:0]  address_select,
  input  logic [7:0]  data_in,
  input  logic [7:0]  alu_result,
  output logic [15:0] address,
  output logic [15:0] pc,
  output logic        cpu_ready
);

  localparam logic [1:0] VEC_LO = 2'd0;
  localparam logic [1:0] VEC_HI = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;

  localparam logic [2:0] SEL_PC         = 3'b000;
  localparam logic [2:0] SEL_ZERO       = 3'b001;
  localparam logic [2:0] SEL_ABS        = 3'b010;
  localparam logic [2:0] SEL_IND_ZERO_0 = 3'b011;
  localparam logic [2:0] SEL_IND_ZERO_1 = 3'b100;
  localparam logic [2:0] SEL_IND_ABS_0  = 3'b101;
  localparam logic [2:0] SEL_IND_ABS_1  = 3'b110;

  // High byte of the vector sits one above the low byte, wrapping at 16 bits
  localparam logic [15:0] VEC_ADDR_HI = VEC_ADDR + 16'd1;

  logic [1:0]  state;
  logic [7:0]  dirl;
  logic [7:0]  dirh;
  logic [7:0]  indirl;
  logic [7:0]  indirh;
  logic        run;
  logic [7:0]  indirl_inc;
  logic [15:0] ind_abs_inc;

  assign run         = (state == RUN);
  // Zero-page pointer increment stays inside page zero
  assign indirl_inc  = indirl + 8'd1;
  // Absolute pointer increment carries into the high byte
  assign ind_abs_inc = {indirh, indirl} + 16'd1;
  // Ready is a pure decode of the state register
  assign cpu_ready   = run;

  // Vector fetch sequencing and program counter update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= VEC_LO;
      pc    <= 16'h0000;
    end else begin
      case (state)
        VEC_LO: begin
          pc[7:0] <= data_in;
          state   <= VEC_HI;
        end
        VEC_HI: begin
          pc[15:8] <= data_in;
          state    <= RUN;
        end
        RUN: begin
          // Jump beats increment; uses the dir bytes as they were before this edge
          if (pc_load) begin
            pc <= {dirh, dirl};
          end else if (increment_pc) begin
            pc <= pc + 16'd1;
          end
        end
        default: begin
          state <= VEC_LO;
        end
      endcase
    end
  end

  // Operand address byte registers, only writable once running
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dirl   <= 8'h00;
      dirh   <= 8'h00;
      indirl <= 8'h00;
      indirh <= 8'h00;
    end else if (run) begin
      if (dirl_load)   dirl   <= alu_result;
      if (dirh_load)   dirh   <= alu_result;
      if (indirl_load) indirl <= data_in;
      if (indirh_load) indirh <= data_in;
    end
  end

  // Address bus source: vector bytes during fetch, selected source when running
  always_comb begin
    address = pc;
    case (state)
      VEC_LO: address = VEC_ADDR;
      VEC_HI: address = VEC_ADDR_HI;
      RUN: begin
        case (address_select)
          SEL_PC:         address = pc;
          SEL_ZERO:       address = {8'h00, dirl};
          SEL_ABS:        address = {dirh, dirl};
          SEL_IND_ZERO_0: address = {8'h00, indirl};
          SEL_IND_ZERO_1: address = {8'h00, indirl_inc};
          SEL_IND_ABS_0:  address = {indirh, indirl};
          SEL_IND_ABS_1:  address = ind_abs_inc;
          default:        address = pc;
        endcase
      end
      default: address = VEC_ADDR;
    endcase
  end

endmodule

// File: tb/tb_address_unit.sv
// tb/tb_address_unit.sv - directed self-checking bench for address_unit
module tb_address_unit;

  logic        clk;
  logic        rst;
  logic        increment_pc;
  logic        pc_load;
  logic        indirl_load;
  logic        indirh_load;
  logic        dirl_load;
  logic        dirh_load;
  logic [2:0]  address_select;
  logic [7:0]  data_in;
  logic [7:0]  alu_result;
  logic [15:0] address;
  logic [15:0] pc;
  logic        cpu_ready;

  int total;
  int bad;

  address_unit #(.VEC_ADDR(16'hFFFC)) dut (
    .clk            (clk),
    .rst            (rst),
    .increment_pc   (increment_pc),
    .pc_load        (pc_load),
    .indirl_load    (indirl_load),
    .indirh_load    (indirh_load),
    .dirl_load      (dirl_load),
    .dirh_load      (dirh_load),
    .address_select (address_select),
    .data_in        (data_in),
    .alu_result     (alu_result),
    .address        (address),
    .pc             (pc),
    .cpu_ready      (cpu_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock with the given strobes, sampled 1ns after the edge, strobes then cleared
  task automatic cyc(input logic inc, input logic pl, input logic il, input logic ih,
                     input logic dl, input logic dh, input logic [7:0] din, input logic [7:0] alu);
    increment_pc = inc;
    pc_load      = pl;
    indirl_load  = il;
    indirh_load  = ih;
    dirl_load    = dl;
    dirh_load    = dh;
    data_in      = din;
    alu_result   = alu;
    @(posedge clk);
    #1;
    increment_pc = 1'b0;
    pc_load      = 1'b0;
    indirl_load  = 1'b0;
    indirh_load  = 1'b0;
    dirl_load    = 1'b0;
    dirh_load    = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst            = 1'b0;
    increment_pc   = 1'b0;
    pc_load        = 1'b0;
    indirl_load    = 1'b0;
    indirh_load    = 1'b0;
    dirl_load      = 1'b0;
    dirh_load      = 1'b0;
    address_select = 3'b000;
    data_in        = 8'h00;
    alu_result     = 8'h00;

    #2;
    check("rst_addr",  address, 16'hFFFC);
    check("rst_pc",    pc, 16'h0000);
    check("rst_ready", {15'd0, cpu_ready}, 16'h0000);

    // Vector fetch 1234
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("vlo_addr", address, 16'hFFFC);
    cyc(0, 0, 0, 0, 0, 0, 8'h34, 8'h00);
    check("vhi_addr",  address, 16'hFFFD);
    check("vhi_ready", {15'd0, cpu_ready}, 16'h0000);
    cyc(0, 0, 0, 0, 0, 0, 8'h12, 8'h00);
    check("vec_pc",    pc, 16'h1234);
    check("run_ready", {15'd0, cpu_ready}, 16'h0001);
    check("run_addr",  address, 16'h1234);

    // PC increment across page and 16-bit wrap
    cyc(0, 0, 0, 0, 1, 0, 8'h00, 8'hFF);
    cyc(0, 0, 0, 0, 0, 1, 8'h00, 8'h12);
    cyc(0, 1, 0, 0, 0, 0, 8'h00, 8'h00);
    check("pc_12ff", pc, 16'h12FF);
    cyc(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    check("pc_1300", pc, 16'h1300);
    cyc(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    check("pc_1301", pc, 16'h1301);
    cyc(0, 0, 0, 0, 0, 1, 8'h00, 8'hFF);
    cyc(0, 1, 0, 0, 0, 0, 8'h00, 8'h00);
    check("pc_ffff", pc, 16'hFFFF);
    cyc(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    check("pc_wrap", pc, 16'h0000);

    // Indirect pointers
    cyc(0, 0, 1, 0, 0, 0, 8'hFF, 8'h00);
    address_select = 3'b100; #1;
    check("indz1_wrap", address, 16'h0000);
    address_select = 3'b011; #1;
    check("indz0", address, 16'h00FF);
    cyc(0, 0, 0, 1, 0, 0, 8'h12, 8'h00);
    address_select = 3'b110; #1;
    check("inda1_carry", address, 16'h1300);
    address_select = 3'b101; #1;
    check("inda0", address, 16'h12FF);
    cyc(0, 0, 0, 1, 0, 0, 8'hFF, 8'h00);
    address_select = 3'b110; #1;
    check("inda1_wrap", address, 16'h0000);

    // Direct registers and pc_load priority
    cyc(0, 0, 0, 0, 1, 0, 8'h00, 8'h80);
    cyc(0, 0, 0, 0, 0, 1, 8'h00, 8'hC0);
    address_select = 3'b001; #1;
    check("zero", address, 16'h0080);
    address_select = 3'b010; #1;
    check("abs", address, 16'hC080);
    cyc(1, 1, 0, 0, 0, 0, 8'h00, 8'h00);
    check("pl_beats_inc", pc, 16'hC080);
    cyc(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    check("pc_c081", pc, 16'hC081);
    cyc(0, 1, 0, 0, 1, 0, 8'h00, 8'h55);
    check("pl_old_dir", pc, 16'hC080);
    address_select = 3'b001; #1;
    check("dirl_new", address, 16'h0055);
    address_select = 3'b111; #1;
    check("sel_rsvd", address, 16'hC080);
    address_select = 3'b000; #1;
    check("sel_pc", address, 16'hC080);

    // Reset mid vector fetch, then fetch with strobes that must be ignored
    rst = 1'b0; #1;
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 8'hAA, 8'h00);
    check("r2_vhi_addr", address, 16'hFFFD);
    #3;
    rst = 1'b0; #1;
    check("r2_ready", {15'd0, cpu_ready}, 16'h0000);
    check("r2_pc",    pc, 16'h0000);
    check("r2_addr",  address, 16'hFFFC);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(1, 1, 1, 1, 1, 1, 8'h78, 8'h77);
    check("r2_vhi2", address, 16'hFFFD);
    cyc(1, 1, 1, 1, 1, 1, 8'h56, 8'h77);
    check("r2_vec_pc", pc, 16'h5678);
    check("r2_ready1", {15'd0, cpu_ready}, 16'h0001);
    address_select = 3'b101; #1;
    check("r2_indir_ign", address, 16'h0000);
    address_select = 3'b010; #1;
    check("r2_dir_ign", address, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
